ifft_input_loader: RTL and testbench
====================================

# ifft_input_loader

- Collects one 16-point frame of serial complex fixed-point samples into a local register file, storing each sample at its bit-reversed index.
- Holds the frame stable until the butterfly datapath releases it.
- Sits directly upstream of the IFFT operand mux:
  - its read port supplies the "fresh input" leg of the mux (`in_0`);
  - the butterfly write-back supplies the other leg.

## Interface
- `DATA_W`, 16: width of each real/imag component, two's complement Q1.15
- `N_POINTS`, 16: frame length; fixed at 16, not a general FFT size
- `ADDR_W`, 4: log2(N_POINTS)
- `clk` in 1: single clock; all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: upstream sample valid
- `in_re` in DATA_W: sample real part
- `in_im` in DATA_W: sample imaginary part
- `in_last` in 1: upstream marks final sample of frame; checked only when the check macro is compiled in
- `in_ready` out 1: loader accepts a sample this cycle
- `frame_ready` out 1: complete frame held, readable
- `rd_addr` in ADDR_W: read index from the IFFT controller, in bit-reversed storage order
- `rd_re` out DATA_W: registered read data, real part
- `rd_im` out DATA_W: registered read data, imaginary part
- `release` in 1: one-cycle pulse from the IFFT controller; frame consumed, buffer may reload
- `frame_err` out 1: sticky frame-length error (check macro only; tied 0 otherwise)

## Operation
- Storage: 16 entries × (re, im), DATA_W each.
- Sample count `cnt`, ADDR_W bits.
- Two-state FSM:
  - LOAD: `in_ready`=1.
    - Accept when `in_valid && in_ready`.
    - Write `{in_re,in_im}` to entry `bitrev(cnt)` (bit order reversed, e.g. 1→8, 3→12), then `cnt`++.
    - Accept with `cnt`==15: `cnt` wraps to 0, go to FULL.
  - FULL: `in_ready`=0, `frame_ready`=1, storage frozen.
    - `release`=1: go to LOAD.
- `release` in LOAD is ignored. This includes the cycle of the 16th accept.
- `in_valid` in FULL is ignored. No write, no count change.
- Read port: every cycle `rd_re/rd_im <= entry[rd_addr]`, in either state.
  - Data is only meaningful while `frame_ready`=1.
- Reset (asserted at any time, including mid-frame):
  - state=LOAD, `cnt`=0;
  - all entries, `rd_re`, `rd_im` = 0;
  - `frame_ready`=0, `frame_err`=0.
  - The partial frame is discarded. `in_ready` is 1 once reset releases.
- No arithmetic. Samples are stored bit-exact, with no scaling or saturation.

## Timing
- `in_ready` and `frame_ready` are decoded directly from the state register, with no combinational path from inputs.
- `frame_ready` rises the cycle after the 16th accepting edge.
- `in_ready` falls on that same cycle.
- Read latency: 1 cycle, `rd_addr` at edge k → data valid after edge k.
- `release` sampled at edge k: `in_ready`=1 and `frame_ready`=0 after edge k. The earliest next accept is at edge k+1.
- Minimum frame turnaround: 16 accept cycles + 1 FULL cycle.

## Configuration
- Macro: `IFFT_LOADER_FRAME_CHK_EN`.
- Defined:
  - `in_last` is checked on every accept.
  - Error case 1: `in_last`=1 with `cnt`≠15. Sets `frame_err` and resets `cnt` to 0, so the frame restarts and the partial data is discarded.
  - Error case 2: `in_last`=0 with `cnt`==15. Sets `frame_err`, but the frame still completes normally.
  - `frame_err` clears only on reset.
- Undefined:
  - `in_last` is ignored.
  - `frame_err` is constant 0.
  - Framing is purely count-based.

## Structure
- Shared header `ifft_defs.vh` holds:
  - `DATA_W`, `N_POINTS`, `ADDR_W` defaults;
  - state encodings LOAD=1'b0, FULL=1'b1.
- The IFFT controller and the butterfly also include `ifft_defs.vh`.
- Sub-module `ifft_bitrev`: combinational ADDR_W-bit index reversal. The IFFT controller reuses it.
- All other logic stays flat in `ifft_input_loader`.

## Test plan
- Reset then stream re=k, im=−k for k=0..15:
  - `frame_ready`=1 one cycle after the 16th accept;
  - `rd_addr`=8 → `rd_re`=1, `rd_im`=−1;
  - `rd_addr`=15 → `rd_re`=15.
- `in_valid`=1 continuously in FULL with re=0x7FFF: no change, `in_ready`=0, the stored frame is intact.
- `release` pulse at edge k:
  - `in_ready`=1 after edge k;
  - next frame starting at edge k+1 overwrites entry 0 with its first sample.
  - `release` during LOAD at `cnt`=5: ignored, count continues.
- Reset asserted mid-frame after 7 accepts:
  - all outputs 0 asynchronously;
  - after deassert, 16 new samples are needed before `frame_ready`.
- Extremes 0x8000/0x7FFF stored and read back bit-exact.
- With `IFFT_LOADER_FRAME_CHK_EN`:
  - `in_last` on the 10th sample → `frame_err`=1, `cnt` restarts;
  - the following clean 16-sample frame completes and `frame_err` stays 1.

Source files
------------

// File: rtl/ifft_input_loader_pkg.sv
// Shared IFFT definitions: default frame geometry and loader state encoding.
package ifft_input_loader_pkg;
  localparam int IFFT_DATA_W   = 16;
  localparam int IFFT_N_POINTS = 16;
  localparam int IFFT_ADDR_W   = 4;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;
endpackage

// File: rtl/ifft_bitrev.sv
// Combinational ADDR_W-bit index reversal; shared with the IFFT controller.
module ifft_bitrev #(
  parameter int ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] rev
);
  always_comb begin
    rev = '0;
    for (int i = 0; i < ADDR_W; i++) rev[i] = idx[ADDR_W-1-i];
  end
endmodule

// File: rtl/ifft_input_loader.sv
// Loads a 16-point complex frame in bit-reversed order and holds it until released.
// Optional in_last framing check: define IFFT_LOADER_FRAME_CHK_EN.
module ifft_input_loader
  import ifft_input_loader_pkg::*;
#(
  parameter int DATA_W   = IFFT_DATA_W,
  parameter int N_POINTS = IFFT_N_POINTS,
  parameter int ADDR_W   = IFFT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              in_last,
  output logic              in_ready,
  output logic              frame_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_re,
  output logic [DATA_W-1:0] rd_im,
  input  logic              frame_release,
  output logic              frame_err
);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(N_POINTS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] wr_idx;
  logic              accept;
  logic              cnt_last;
  logic              restart;
  logic [DATA_W-1:0] mem_re [N_POINTS];
  logic [DATA_W-1:0] mem_im [N_POINTS];

  assign accept   = in_valid && in_ready;
  assign cnt_last = (cnt == LAST_CNT);

  ifft_bitrev #(.ADDR_W(ADDR_W)) u_bitrev (
    .idx (cnt),
    .rev (wr_idx)
  );

`ifdef IFFT_LOADER_FRAME_CHK_EN
  // Early in_last restarts the frame; a missing in_last only flags the error.
  assign restart = accept && in_last && !cnt_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              frame_err <= 1'b0;
    else if (accept && (in_last != cnt_last)) frame_err <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = in_last;
  assign restart     = 1'b0;
  assign frame_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && cnt_last) state_nxt = FULL;
      FULL:    if (frame_release)      state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    frame_ready = 1'b0;
    in_ready    = (state == LOAD);
    frame_ready = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (accept) cnt <= restart ? '0 : cnt + ADDR_W'(1);
  end

  // Read port runs every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_POINTS; i++) begin
        mem_re[i] <= '0;
        mem_im[i] <= '0;
      end
      rd_re <= '0;
      rd_im <= '0;
    end else begin
      if (accept) begin
        mem_re[wr_idx] <= in_re;
        mem_im[wr_idx] <= in_im;
      end
      rd_re <= mem_re[rd_addr];
      rd_im <= mem_im[rd_addr];
    end
  end
endmodule

// File: tb/tb_ifft_input_loader.sv
// Directed self-checking bench for ifft_input_loader with a read-data scoreboard.
module tb_ifft_input_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        frame_ready;
  logic [3:0]  rd_addr = '0;
  logic [15:0] rd_re;
  logic [15:0] rd_im;
  logic        frame_release = 1'b0;
  logic        frame_err;

  int tests = 0;
  int fails = 0;

  logic [15:0] model_re [16];
  logic [15:0] model_im [16];
  int          model_cnt = 0;
  bit          model_full = 1'b0;
  logic [31:0] exp_q [$];

  ifft_input_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_re         (in_re),
    .in_im         (in_im),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .frame_ready   (frame_ready),
    .rd_addr       (rd_addr),
    .rd_re         (rd_re),
    .rd_im         (rd_im),
    .frame_release (frame_release),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rev4(input int v);
    logic [3:0] x, r;
    x = v[3:0];
    for (int i = 0; i < 4; i++) r[i] = x[3-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      model_re[i] = '0;
      model_im[i] = '0;
    end
    model_cnt  = 0;
    model_full = 1'b0;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    if (!model_full) begin
      model_re[rev4(model_cnt)] = re;
      model_im[rev4(model_cnt)] = im;
`ifdef IFFT_LOADER_FRAME_CHK_EN
      if (last && model_cnt != 15) model_cnt = 0;
      else begin
`endif
        if (model_cnt == 15) begin
          model_cnt  = 0;
          model_full = 1'b1;
        end else model_cnt++;
`ifdef IFFT_LOADER_FRAME_CHK_EN
      end
`endif
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_pulse();
    frame_release = 1'b1;
    if (model_full) model_full = 1'b0;
    tick();
    frame_release = 1'b0;
  endtask

  task automatic read_check(input string tag, input int a);
    logic [31:0] e;
    rd_addr = a[3:0];
    exp_q.push_back({model_re[a], model_im[a]});
    tick();
    e = exp_q.pop_front();
    check(tag, {rd_re, rd_im}, e);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) read_check(tag, a);
  endtask

  initial begin
    model_clear();
    // Reset state
    #12;
    check("rst_frame_ready", 32'(frame_ready), 32'd0);
    check("rst_rd", {rd_re, rd_im}, 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Frame 1: re=k, im=-k
    for (int k = 0; k < 15; k++) send(16'(k), 16'(-k), 1'b0);
    check("f1_not_ready_15", 32'(frame_ready), 32'd0);
    send(16'd15, 16'(-15), 1'b1);
    check("f1_frame_ready", 32'(frame_ready), 32'd1);
    check("f1_in_ready_low", 32'(in_ready), 32'd0);
    rd_addr = 4'd8;
    exp_q.push_back({16'h0001, 16'hFFFF});
    tick();
    check("f1_addr8", {rd_re, rd_im}, exp_q.pop_front());
    rd_addr = 4'd15;
    exp_q.push_back({16'h000F, 16'hFFF1});
    tick();
    check("f1_addr15", {rd_re, rd_im}, exp_q.pop_front());
    read_all("f1_read");

    // in_valid held in FULL is ignored
    in_valid = 1'b1;
    in_re    = 16'h7FFF;
    in_im    = 16'h7FFF;
    for (int i = 0; i < 5; i++) tick();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_frame_ready", 32'(frame_ready), 32'd1);
    in_valid = 1'b0;
    read_all("full_intact");

    // Release, then immediate next frame
    release_pulse();
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_frame_ready", 32'(frame_ready), 32'd0);
    send(16'h8000, 16'h7FFF, 1'b0);
    read_check("f2_entry0", 0);
    for (int k = 1; k < 5; k++) send(16'h1000 + 16'(k), 16'(k), 1'b0);
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    check("rel_load_ignored", 32'(in_ready), 32'd1);
    for (int k = 5; k < 15; k++) send(16'h2000 + 16'(k), 16'h8000 + 16'(k), 1'b0);
    check("f2_not_ready_15", 32'(frame_ready), 32'd0);
    send(16'h7FFF, 16'h8000, 1'b1);
    check("f2_frame_ready", 32'(frame_ready), 32'd1);
    read_all("f2_extremes");

    // Mid-frame asynchronous reset after 7 accepts
    release_pulse();
    for (int k = 0; k < 7; k++) send(16'h3000 + 16'(k), 16'h3100 + 16'(k), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_frame_ready", 32'(frame_ready), 32'd0);
    check("mrst_rd", {rd_re, rd_im}, 32'd0);
    check("mrst_frame_err", 32'(frame_err), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    read_check("mrst_entry", 3);
    for (int k = 0; k < 15; k++) send(16'h4000 + 16'(k), 16'hC000 + 16'(k), 1'b0);
    check("mrst_not_ready_15", 32'(frame_ready), 32'd0);
    send(16'h400F, 16'hC00F, 1'b1);
    check("mrst_frame_ready", 32'(frame_ready), 32'd1);
    read_all("mrst_read");

`ifdef IFFT_LOADER_FRAME_CHK_EN
    release_pulse();
    for (int k = 0; k < 9; k++) send(16'h5000 + 16'(k), 16'h5100 + 16'(k), 1'b0);
    send(16'h5009, 16'h5109, 1'b1);
    check("chk_err_set", 32'(frame_err), 32'd1);
    check("chk_restart_loading", 32'(frame_ready), 32'd0);
    for (int k = 0; k < 15; k++) send(16'h6000 + 16'(k), 16'h6100 + 16'(k), 1'b0);
    check("chk_not_ready_15", 32'(frame_ready), 32'd0);
    send(16'h600F, 16'h610F, 1'b1);
    check("chk_frame_ready", 32'(frame_ready), 32'd1);
    check("chk_err_sticky", 32'(frame_err), 32'd1);
    read_all("chk_read");
`else
    check("nochk_frame_err", 32'(frame_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
